codec_adc_receiver: RTL and testbench
=====================================

# codec_adc_receiver

Captures stereo audio from the codec ADC serial port and delivers parallel left/right sample pairs to the fabric over a valid/ready interface. It is the receive-side counterpart of the DAC playback path. It runs in the codec master-clock domain (aud_xck, 18.432 MHz) and observes the same FPGA-generated BCLK and LRCK used by the DAC path. The codec runs in left-justified mode: LRCK high carries the left channel, MSB first, and data changes on BCLK falling edges.

## Interface
One clock, `clk`. Reset `rst` is synchronous and active-high.
- SAMPLE_WIDTH, 16: bits captured per channel; range 8..24.
- clk  in  1  codec master clock (aud_xck domain).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; level-sensitive.
- aud_bclk  in  1  bit clock (same net as the DAC BCLK).
- aud_adclrck  in  1  ADC LR clock; high = left.
- aud_adcdat  in  1  serial ADC data from the codec.
- left_sample  out  SAMPLE_WIDTH  two's-complement left sample.
- right_sample  out  SAMPLE_WIDTH  two's-complement right sample.
- sample_valid  out  1  output register holds an unconsumed frame.
- sample_ready  in  1  consumer accepts the frame.
- overrun  out  1  one-cycle pulse: an unconsumed frame was overwritten.

## Operation
- Pin sampling: all three pins pass through a 2-flop synchronizer and then a registered edge detector. Detected events are bclk_rise, lrck_rise and lrck_fall.
- States: IDLE, LEFT, RIGHT.
  - IDLE: on lrck_rise with enable=1, go to LEFT, set bit_cnt=0, clear the shift register.
  - LEFT: on each bclk_rise with bit_cnt<SAMPLE_WIDTH, shift in adcdat (MSB first) and increment bit_cnt. Further bits are ignored. On lrck_fall, latch the left word, set bit_cnt=0, go to RIGHT.
  - RIGHT: same shifting. On the bclk_rise that captures bit SAMPLE_WIDTH-1, commit the frame and go to IDLE-aligned wait. The next lrck_rise re-enters LEFT.
  - Short slot: if LRCK toggles before SAMPLE_WIDTH bits arrive, the missing LSBs are zero-filled and the word is latched at that edge. If the right slot is short, the frame commits at lrck_rise, and that same edge starts the next LEFT.
- Simultaneous edges: lrck_fall or lrck_rise with bclk_rise in the same cycle means the bclk_rise belongs to the new slot (bit 0 of the new channel).
- enable=0: return to IDLE in the next cycle and discard the partial frame. The output register and handshake are unaffected. On re-enable, wait for a fresh lrck_rise. A capture never starts mid-frame.
- Output register: one entry.
  - A commit loads left_sample and right_sample and sets sample_valid.
  - Transfer occurs when sample_valid && sample_ready. sample_valid clears next cycle unless a commit happens in the same cycle.
  - Commit while sample_valid=1 and no transfer in that cycle: overwrite (freshest data wins) and pulse overrun.
  - Commit in the same cycle as a transfer: load the new frame, keep valid high, no overrun.
- Reset values: state=IDLE, bit_cnt=0, left_sample=0, right_sample=0, sample_valid=0, overrun=0. Synchronizer flops also reset to 0.

## Timing
- Pin-to-event latency: 3 clk (2 synchronizer + 1 edge register).
- sample_valid rises 1 clk after the cycle in which the final right bit's bclk_rise is detected.
- overrun pulses in the same cycle the overwriting commit becomes visible.
- With the standard dividers (BCLK toggling every 36 clk, LRCK every 1152 clk) a slot holds 16 BCLK rises. SAMPLE_WIDTH ≤ 16 therefore never short-slots.
- Ready may be held high permanently. Minimum frame spacing is one LRCK period (2304 clk).

## Structure
- Shared package codec_pkg:
  - SAMPLE_WIDTH default.
  - rx_state_t enum (IDLE, LEFT, RIGHT).
  - Divider constants BCLK_DIVIDER and LRCK_DIVIDER, for the bench's clock model.
- bit_cnt width: $clog2(SAMPLE_WIDTH+1).
- One sub-module, codec_pin_sampler: 2-flop synchronization of BCLK/LRCK/ADCDAT plus rise/fall detection, with synchronous active-high reset. The existing async active-low synchronizer and edge detector are not reused.

## Test plan
1. Nominal frame: left=16'h8001, right=16'h7FFE driven left-justified with standard dividers and ready=1 → one sample_valid pulse with those exact values; sample_valid 1 clk after the last right bit's bclk_rise + 3 clk.
2. Backpressure: ready=0 across two frames (A=16'h1234/16'h5678, B=16'hABCD/16'h0F0F) → overrun pulses once, outputs hold B, valid stays 1. Raise ready → valid drops the next cycle.
3. Mid-frame start: assert enable while LRCK is low, mid right slot → no commit until after the first full left+right frame. The first frame out is the complete one.
4. Short slot: LRCK toggled after 12 bits with SAMPLE_WIDTH=16 and data 12'hFFF → word = 16'hFFF0, committed at the edge.
5. enable dropped after 8 left bits, then re-raised → partial frame discarded, no valid pulse. The next full frame is captured correctly.
6. rst asserted mid-RIGHT with sample_valid=1 → all outputs 0 on the next cycle, and capture resumes only at the next lrck_rise.

Source files
------------

// File: rtl/codec_pkg.sv
// codec_pkg
// Shared definitions for the codec audio paths: default sample width,
// receive-side state encoding and the standard BCLK/LRCK divider ratios.
// The divider ratios are expressed in aud_xck cycles per half-period.
// The DAC path and clock-model benches use them to generate or predict
// BCLK and LRCK.
package codec_pkg;

    // Default bits captured per channel.
    localparam int SAMPLE_WIDTH_DEFAULT = 16;

    // BCLK toggles every BCLK_DIVIDER master clocks.
    // LRCK toggles every LRCK_DIVIDER master clocks.
    localparam int BCLK_DIVIDER = 36;
    localparam int LRCK_DIVIDER = 1152;

    // Receive framing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/codec_pin_sampler.sv
// codec_pin_sampler
// Brings the codec serial pins into the aud_xck domain through a two-flop
// synchronizer. It then registers the BCLK rise and LRCK rise/fall events.
// The data bit is delayed by the same amount as the events, so the bit that
// accompanies bclk_rise_o is the one present when BCLK rose.
// Total pin-to-event latency is 3 clk.
//
// Ports:
//   clk          in   codec master clock
//   rst          in   synchronous active-high reset
//   bclk_i       in   raw BCLK pin
//   lrck_i       in   raw ADC LRCK pin
//   dat_i        in   raw ADC data pin
//   bclk_rise_o  out  one-cycle BCLK rising-edge event
//   lrck_rise_o  out  one-cycle LRCK rising-edge event (left slot start)
//   lrck_fall_o  out  one-cycle LRCK falling-edge event (right slot start)
//   dat_o        out  data bit aligned with the events
module codec_pin_sampler (
    input  logic clk,
    input  logic rst,
    input  logic bclk_i,
    input  logic lrck_i,
    input  logic dat_i,
    output logic bclk_rise_o,
    output logic lrck_rise_o,
    output logic lrck_fall_o,
    output logic dat_o
);

    // Bit order in the packed synchronizer vectors is {bclk, lrck, dat}.
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       bclkPrev_q;
    logic       lrckPrev_q;
    logic       bclkRise_q;
    logic       lrckRise_q;
    logic       lrckFall_q;
    logic       dat_q;

    // Synchronizer chain followed by registered edge detection.
    // The prev flops hold the previous synchronized level. An edge is flagged
    // when the synchronized level differs from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            bclkPrev_q <= 1'b0;
            lrckPrev_q <= 1'b0;
            bclkRise_q <= 1'b0;
            lrckRise_q <= 1'b0;
            lrckFall_q <= 1'b0;
            dat_q      <= 1'b0;
        end else begin
            sync1_q    <= {bclk_i, lrck_i, dat_i};
            sync2_q    <= sync1_q;
            bclkPrev_q <= sync2_q[2];
            lrckPrev_q <= sync2_q[1];
            bclkRise_q <= sync2_q[2] & ~bclkPrev_q;
            lrckRise_q <= sync2_q[1] & ~lrckPrev_q;
            lrckFall_q <= ~sync2_q[1] & lrckPrev_q;
            dat_q      <= sync2_q[0];
        end
    end

    assign bclk_rise_o = bclkRise_q;
    assign lrck_rise_o = lrckRise_q;
    assign lrck_fall_o = lrckFall_q;
    assign dat_o       = dat_q;

endmodule

// File: rtl/codec_adc_receiver.sv
// codec_adc_receiver
// Deserializes left-justified stereo ADC data (LRCK high = left, MSB first)
// into parallel left/right pairs. The pairs are offered through a one-entry
// valid/ready output register.
// If a slot is cut short, the missing LSBs are zero-filled.
// If a new frame arrives while one is still unconsumed, the new frame
// overwrites it and overrun pulses.
//
// Ports:
//   clk           in   codec master clock (aud_xck)
//   rst           in   synchronous active-high reset
//   enable        in   capture enable; capture starts only at an LRCK rise
//   aud_bclk      in   bit clock
//   aud_adclrck   in   ADC LR clock, high = left
//   aud_adcdat    in   serial ADC data
//   left_sample   out  left word of the held frame
//   right_sample  out  right word of the held frame
//   sample_valid  out  output register holds an unconsumed frame
//   sample_ready  in   consumer accepts the frame
//   overrun       out  one-cycle pulse when an unconsumed frame is replaced
module codec_adc_receiver
    import codec_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    aud_bclk,
    input  logic                    aud_adclrck,
    input  logic                    aud_adcdat,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_WIDTH - 1);

    logic bclkRise;
    logic lrckRise;
    logic lrckFall;
    logic adcDat;

    rx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] leftWord_q, leftWord_d;
    logic [SAMPLE_WIDTH-1:0] leftSample_q, leftSample_d;
    logic [SAMPLE_WIDTH-1:0] rightSample_q, rightSample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic [SAMPLE_WIDTH-1:0] shiftIn;
    logic [SAMPLE_WIDTH-1:0] zeroFilled;
    logic [SAMPLE_WIDTH-1:0] slotStartShift;
    logic [CNT_W-1:0]        slotStartCnt;
    logic [SAMPLE_WIDTH-1:0] commitRight;
    logic                    commit;

    codec_pin_sampler u_pin_sampler (
        .clk         (clk),
        .rst         (rst),
        .bclk_i      (aud_bclk),
        .lrck_i      (aud_adclrck),
        .dat_i       (aud_adcdat),
        .bclk_rise_o (bclkRise),
        .lrck_rise_o (lrckRise),
        .lrck_fall_o (lrckFall),
        .dat_o       (adcDat)
    );

    // The shift register fills from the LSB end.
    // A word latched early is shifted up so the received bits land in the
    // MSBs and zeros fill the LSBs.
    // A BCLK rise in the same cycle as an LRCK edge is bit 0 of the new slot.
    // That is why a slot can start with one bit already captured.
    assign shiftIn        = {shift_q[SAMPLE_WIDTH-2:0], adcDat};
    assign zeroFilled     = shift_q << (CNT_FULL - bitCnt_q);
    assign slotStartShift = bclkRise ? {{(SAMPLE_WIDTH-1){1'b0}}, adcDat} : '0;
    assign slotStartCnt   = bclkRise ? CNT_ONE : '0;

    // Framing FSM and output-register next-state logic.
    // The output register is updated independently of framing, so dropping
    // enable never disturbs a frame that is waiting for the consumer.
    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        shift_d       = shift_q;
        leftWord_d    = leftWord_q;
        commit        = 1'b0;
        commitRight   = zeroFilled;

        unique case (state_q)
            IDLE: begin
                if (enable && lrckRise) begin
                    state_d  = LEFT;
                    bitCnt_d = slotStartCnt;
                    shift_d  = slotStartShift;
                end
            end
            LEFT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else if (lrckFall) begin
                    leftWord_d = zeroFilled;
                    state_d    = RIGHT;
                    bitCnt_d   = slotStartCnt;
                    shift_d    = slotStartShift;
                end else if (bclkRise && bitCnt_q < CNT_FULL) begin
                    shift_d  = shiftIn;
                    bitCnt_d = bitCnt_q + CNT_ONE;
                end
            end
            RIGHT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else if (lrckRise) begin
                    // Short right slot: commit now and start the next left slot.
                    commit      = 1'b1;
                    commitRight = zeroFilled;
                    state_d     = LEFT;
                    bitCnt_d    = slotStartCnt;
                    shift_d     = slotStartShift;
                end else if (bclkRise && bitCnt_q < CNT_FULL) begin
                    shift_d  = shiftIn;
                    bitCnt_d = bitCnt_q + CNT_ONE;
                    if (bitCnt_q == CNT_LAST) begin
                        commit      = 1'b1;
                        commitRight = shiftIn;
                        state_d     = IDLE;
                        bitCnt_d    = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        endcase

        leftSample_d  = leftSample_q;
        rightSample_d = rightSample_q;
        valid_d       = valid_q;
        overrun_d     = 1'b0;
        if (commit) begin
            leftSample_d  = leftWord_q;
            rightSample_d = commitRight;
            valid_d       = 1'b1;
            overrun_d     = valid_q && !sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // All state and outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            leftWord_q    <= '0;
            leftSample_q  <= '0;
            rightSample_q <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitCnt_q      <= bitCnt_d;
            shift_q       <= shift_d;
            leftWord_q    <= leftWord_d;
            leftSample_q  <= leftSample_d;
            rightSample_q <= rightSample_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign left_sample  = leftSample_q;
    assign right_sample = rightSample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_codec_adc_receiver.sv
// tb_codec_adc_receiver
// Drives left-justified codec frames with the standard divider timing.
// Expected frames are queued when they are issued. A monitor process pops
// and compares a frame whenever the DUT hands one over on valid && ready.
module tb_codec_adc_receiver;
    import codec_pkg::*;

    localparam int W         = 16;
    localparam int SLOT_BITS = LRCK_DIVIDER / (2 * BCLK_DIVIDER);
    localparam int ACT_NONE  = 0;
    localparam int ACT_EN    = 1;
    localparam int ACT_DIS   = 2;
    localparam int ACT_RST   = 3;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         aud_bclk;
    logic         aud_adclrck;
    logic         aud_adcdat;
    logic         sample_ready;
    logic [W-1:0] left_sample;
    logic [W-1:0] right_sample;
    logic         sample_valid;
    logic         overrun;

    int     checks = 0;
    int     passes = 0;
    int     cycle = 0;
    int     lastRiseCycle = 0;
    int     validRiseCycle = 0;
    int     commitSeen = 0;
    int     overrunSeen = 0;
    int     c0;
    int     o0;
    logic   validPrev = 1'b0;
    frame_t expQ[$];

    codec_adc_receiver #(.SAMPLE_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Inputs change 1 time unit after a rising clock edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One LRCK slot of nper BCLK periods carrying the top nbits of word.
    // act is applied at the falling BCLK edge of period actIdx.
    task automatic applyStimulus(input logic lr, input logic [W-1:0] word, input int nbits,
                                 input int nper, input int actIdx, input int act);
        logic [W-1:0] tmp;
        for (int i = 0; i < nper; i++) begin
            aud_bclk = 1'b0;
            if (i == 0) aud_adclrck = lr;
            tmp = word << i;
            aud_adcdat = (i < nbits) ? tmp[W-1] : 1'b0;
            if (i == actIdx) begin
                case (act)
                    ACT_EN:  enable = 1'b1;
                    ACT_DIS: enable = 1'b0;
                    ACT_RST: begin
                        rst = 1'b1;
                        tick(1);
                        checkOutput("mid-frame reset samples", {left_sample, right_sample}, 32'h0);
                        checkOutput("mid-frame reset flags", {30'h0, sample_valid, overrun}, 32'h0);
                        rst = 1'b0;
                    end
                    default: ;
                endcase
            end
            tick(BCLK_DIVIDER);
            aud_bclk = 1'b1;
            lastRiseCycle = cycle;
            tick(BCLK_DIVIDER);
        end
    endtask

    task automatic applyFrame(input logic [W-1:0] l, input logic [W-1:0] r);
        applyStimulus(1'b1, l, W, SLOT_BITS, -1, ACT_NONE);
        applyStimulus(1'b0, r, W, SLOT_BITS, -1, ACT_NONE);
    endtask

    // Monitor: records commits and overruns, and scores every handed-over frame.
    always @(negedge clk) begin
        frame_t e;
        if (!rst) begin
            if (sample_valid && !validPrev) begin
                commitSeen++;
                validRiseCycle = cycle;
            end
            if (overrun) overrunSeen++;
            if (sample_valid && sample_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected frame: got %h_%h, expected none", left_sample, right_sample);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("frame", {left_sample, right_sample}, {e.l, e.r});
                end
            end
        end
        validPrev = sample_valid;
    end

    // Watchdog.
    initial begin
        repeat (90000) @(posedge clk);
        checks++;
        $display("[TB] FAIL watchdog: simulation exceeded %0d cycles", 90000);
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b1;
        aud_bclk     = 1'b1;
        aud_adclrck  = 1'b0;
        aud_adcdat   = 1'b0;
        sample_ready = 1'b1;
        tick(3);
        checkOutput("reset samples", {left_sample, right_sample}, 32'h0);
        checkOutput("reset flags", {30'h0, sample_valid, overrun}, 32'h0);
        rst = 1'b0;
        tick(5);

        // Nominal frame, ready held high.
        c0 = commitSeen;
        expQ.push_back('{l: 16'h8001, r: 16'h7FFE});
        applyFrame(16'h8001, 16'h7FFE);
        checkOutput("nominal latency", 32'(validRiseCycle - lastRiseCycle), 32'd4);
        checkOutput("nominal commits", 32'(commitSeen - c0), 32'd1);

        // Backpressure across two frames: B overwrites A.
        sample_ready = 1'b0;
        o0 = overrunSeen;
        expQ.push_back('{l: 16'hABCD, r: 16'h0F0F});
        applyFrame(16'h1234, 16'h5678);
        applyFrame(16'hABCD, 16'h0F0F);
        checkOutput("overrun pulses", 32'(overrunSeen - o0), 32'd1);
        checkOutput("held valid", {31'h0, sample_valid}, 32'd1);
        checkOutput("held frame", {left_sample, right_sample}, 32'hABCD_0F0F);
        sample_ready = 1'b1;
        tick(1);
        checkOutput("valid drop after ready", {31'h0, sample_valid}, 32'd0);

        // Enable raised mid right slot: that frame is not captured.
        enable = 1'b0;
        c0 = commitSeen;
        expQ.push_back('{l: 16'h3333, r: 16'h4444});
        applyStimulus(1'b1, 16'h1111, W, SLOT_BITS, -1, ACT_NONE);
        applyStimulus(1'b0, 16'h2222, W, SLOT_BITS, 8, ACT_EN);
        applyFrame(16'h3333, 16'h4444);
        checkOutput("mid-frame start commits", 32'(commitSeen - c0), 32'd1);

        // Short left slot (12 bits), then a short right slot (10 bits) that
        // commits at the following LRCK rise.
        c0 = commitSeen;
        expQ.push_back('{l: 16'hFFF0, r: 16'h0001});
        expQ.push_back('{l: 16'hA5A5, r: 16'hFFC0});
        expQ.push_back('{l: 16'h0F00, r: 16'h00F0});
        applyStimulus(1'b1, 16'hFFF0, 12, 12, -1, ACT_NONE);
        applyStimulus(1'b0, 16'h0001, W, SLOT_BITS, -1, ACT_NONE);
        applyStimulus(1'b1, 16'hA5A5, W, SLOT_BITS, -1, ACT_NONE);
        applyStimulus(1'b0, 16'hFFC0, 10, 10, -1, ACT_NONE);
        applyFrame(16'h0F00, 16'h00F0);
        checkOutput("short slot commits", 32'(commitSeen - c0), 32'd3);

        // Enable dropped after 8 left bits, restored mid right slot.
        c0 = commitSeen;
        expQ.push_back('{l: 16'hCAFE, r: 16'hBEEF});
        applyStimulus(1'b1, 16'h1357, W, SLOT_BITS, 8, ACT_DIS);
        applyStimulus(1'b0, 16'h2468, W, SLOT_BITS, 4, ACT_EN);
        applyFrame(16'hCAFE, 16'hBEEF);
        checkOutput("disable discard commits", 32'(commitSeen - c0), 32'd1);

        // Reset in the middle of a right slot while a frame is held.
        sample_ready = 1'b0;
        applyFrame(16'h5A5A, 16'hA5A5);
        applyStimulus(1'b1, 16'h7777, W, SLOT_BITS, -1, ACT_NONE);
        checkOutput("valid before reset", {31'h0, sample_valid}, 32'd1);
        applyStimulus(1'b0, 16'h8888, W, SLOT_BITS, 8, ACT_RST);
        sample_ready = 1'b1;
        c0 = commitSeen;
        expQ.push_back('{l: 16'h1F2E, r: 16'h3D4C});
        applyFrame(16'h1F2E, 16'h3D4C);
        checkOutput("post-reset commits", 32'(commitSeen - c0), 32'd1);

        tick(10);
        checkOutput("queue drained", 32'(expQ.size()), 32'd0);
        checkOutput("total overruns", 32'(overrunSeen), 32'd1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
